// File: rtl/seq_addsub.sv
// Multi-cycle N-bit adder/subtractor: one W-bit chunk per clock through a short carry chain.
// S/CO/OV are published together on the completion edge and held until the next completion.
module seq_addsub #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic         SUB,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CI,
  output logic         BUSY,
  output logic         DONE,
  output logic [N-1:0] S,
  output logic         CO,
  output logic         OV
);
  localparam int K  = N / W;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d, p_q, p_d, s_q, s_d;
  logic          c_q, c_d, co_q, co_d, ov_q, ov_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_chunk, b_chunk;
  logic [W:0]    sum;
  logic          accept, last;

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // START is only honoured outside RUN, so in-flight operands are never re-sampled
  assign accept = START && (state_q != RUN);
  assign last   = (cnt_q == LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (START) state_d = RUN;
      RUN:     if (last)  state_d = FIN;
      FIN:     state_d = START ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state_q == RUN);
    DONE = (state_q == FIN);
    S    = s_q;
    CO   = co_q;
    OV   = ov_q;
  end

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < K; k++) begin
      if (cnt_q == CW'(k)) begin
        a_chunk = a_q[k*W +: W];
        b_chunk = b_q[k*W +: W];
      end
    end
    sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{W{1'b0}}, c_q};

    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    p_d   = p_q;
    cnt_d = cnt_q;
    s_d   = s_q;
    co_d  = co_q;
    ov_d  = ov_q;

    if (accept) begin
      // Subtraction as A + ~B + !CI: the borrow-in becomes an inverted carry-in
      a_d   = A;
      b_d   = SUB ? ~B : B;
      c_d   = SUB ? ~CI : CI;
      p_d   = '0;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      for (int k = 0; k < K; k++) begin
        if (cnt_q == CW'(k)) p_d[k*W +: W] = sum[W-1:0];
      end
      c_d   = sum[W];
      cnt_d = last ? '0 : cnt_q + 1'b1;
      if (last) begin
        s_d  = p_d;
        co_d = sum[W];
        ov_d = signed_ovf(a_q[N-1], b_q[N-1], p_d[N-1]);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
      s_q   <= '0;
      co_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      p_q   <= p_d;
      c_q   <= c_d;
      cnt_q <= cnt_d;
      s_q   <= s_d;
      co_q  <= co_d;
      ov_q  <= ov_d;
    end
  end

endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: three instances (W=8, W=1, W=32) share operands and are checked
// against a plain integer arithmetic model of add/subtract, carry-out and signed overflow.
module tb_seq_addsub;
  localparam int WS [3] = '{8, 1, 32};
  localparam int KS [3] = '{4, 32, 1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start = '0;
  logic        in_sub = 1'b0;
  logic        in_ci = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [2:0]  busy, done, co, ov;
  logic [31:0] s_o [3];

  logic [31:0] last_s [3];
  logic [2:0]  last_co, last_ov;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_addsub #(.N(32), .W(8)) u_w8 (
    .CLK(clk), .RST_N(rst_n), .START(start[0]), .SUB(in_sub), .A(in_a), .B(in_b), .CI(in_ci),
    .BUSY(busy[0]), .DONE(done[0]), .S(s_o[0]), .CO(co[0]), .OV(ov[0]));
  seq_addsub #(.N(32), .W(1)) u_w1 (
    .CLK(clk), .RST_N(rst_n), .START(start[1]), .SUB(in_sub), .A(in_a), .B(in_b), .CI(in_ci),
    .BUSY(busy[1]), .DONE(done[1]), .S(s_o[1]), .CO(co[1]), .OV(ov[1]));
  seq_addsub #(.N(32), .W(32)) u_w32 (
    .CLK(clk), .RST_N(rst_n), .START(start[2]), .SUB(in_sub), .A(in_a), .B(in_b), .CI(in_ci),
    .BUSY(busy[2]), .DONE(done[2]), .S(s_o[2]), .CO(co[2]), .OV(ov[2]));

  // Reference: exact integer result, then carry/no-borrow and signed range test
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic ci,
                                input logic sub, output logic [31:0] s, output logic c,
                                output logic v);
    longint ua, ub, sa, sb, ur, sr, uci;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    uci = longint'(ci);
    if (!sub) begin
      ur = ua + ub + uci;
      sr = sa + sb + uci;
      c  = (ur > 64'sd4294967295);
    end else begin
      ur = ua - ub - uci;
      sr = sa - sb - uci;
      c  = (ur >= 64'sd0);
    end
    s = ur[31:0];
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endfunction

  function automatic string tag(input string name, input int d, input int c);
    return $sformatf("%s w%0d c%0d", name, WS[d], c);
  endfunction

  task automatic chk1(input string t, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", t, obs, exp);
    end
  endtask

  task automatic chk32(input string t, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", t, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    in_a   = $urandom;
    in_b   = $urandom;
    in_ci  = 1'($urandom);
    in_sub = 1'($urandom);
  endtask

  task automatic chk_outputs(input string name, input int d, input int c,
                             input logic [31:0] es, input logic eco, input logic eov);
    chk32(tag({name, " S"}, d, c), s_o[d], es);
    chk1(tag({name, " CO"}, d, c), co[d], eco);
    chk1(tag({name, " OV"}, d, c), ov[d], eov);
  endtask

  // One operation on all three instances; poke re-asserts START with new operands mid-run
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                    input logic sub, input bit poke);
    logic [31:0] es;
    logic eco, eov;
    model(a, b, ci, sub, es, eco, eov);
    @(negedge clk);
    in_a = a; in_b = b; in_ci = ci; in_sub = sub; start = 3'b111;
    @(posedge clk); #1;
    start = '0;
    scramble_inputs();
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (poke && c == 3) start = '0;
      for (int d = 0; d < 3; d++) begin
        chk1(tag("BUSY", d, c), busy[d], c <= KS[d]);
        chk1(tag("DONE", d, c), done[d], c == KS[d] + 1);
        if (c <= KS[d]) chk_outputs("hold", d, c, last_s[d], last_co[d], last_ov[d]);
        else            chk_outputs("result", d, c, es, eco, eov);
      end
      if (poke && c == 2) begin
        start = 3'b011;
        scramble_inputs();
      end
    end
    for (int d = 0; d < 3; d++) begin
      last_s[d] = es; last_co[d] = eco; last_ov[d] = eov;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] es;
    logic eco, eov;
    for (int d = 0; d < 3; d++) last_s[d] = '0;
    last_co = '0;
    last_ov = '0;

    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk1(tag("reset BUSY", d, 0), busy[d], 1'b0);
      chk1(tag("reset DONE", d, 0), done[d], 1'b0);
      chk_outputs("reset", d, 0, 32'h0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    op(32'd10,        32'd3,         1'b1, 1'b1, 1'b0);
    op(32'd3,         32'd10,        1'b0, 1'b1, 1'b0);
    op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    op($urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);

    // Back-to-back on the W=8 instance: START during the DONE cycle
    model(32'd100, 32'd23, 1'b0, 1'b0, es, eco, eov);
    @(negedge clk);
    in_a = 32'd100; in_b = 32'd23; in_ci = 1'b0; in_sub = 1'b0; start = 3'b001;
    @(posedge clk); #1;
    start = '0;
    scramble_inputs();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk1(tag("b2b BUSY", 0, c), busy[0], 1'b1);
      chk1(tag("b2b DONE", 0, c), done[0], 1'b0);
      chk32(tag("b2b hold S", 0, c), s_o[0], last_s[0]);
    end
    @(negedge clk);
    chk1(tag("b2b DONE", 0, 5), done[0], 1'b1);
    chk1(tag("b2b BUSY", 0, 5), busy[0], 1'b0);
    chk_outputs("b2b first", 0, 5, es, eco, eov);
    in_a = 32'd5; in_b = 32'd7; in_ci = 1'b0; in_sub = 1'b0; start = 3'b001;
    @(posedge clk); #1;
    start = '0;
    scramble_inputs();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk1(tag("b2b2 BUSY", 0, c), busy[0], 1'b1);
      chk1(tag("b2b2 DONE", 0, c), done[0], 1'b0);
      chk32(tag("b2b2 hold S", 0, c), s_o[0], es);
    end
    @(negedge clk);
    chk1(tag("b2b2 DONE", 0, 5), done[0], 1'b1);
    chk_outputs("b2b2 second", 0, 5, 32'd12, 1'b0, 1'b0);
    last_s[0] = 32'd12; last_co[0] = 1'b0; last_ov[0] = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) op($urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0);

    // Asynchronous reset while the W=8 instance is processing chunk 2
    @(negedge clk);
    in_a = $urandom | 32'h1; in_b = $urandom; in_ci = 1'b0; in_sub = 1'b0; start = 3'b111;
    @(posedge clk); #1;
    start = '0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk1(tag("midreset BUSY", d, 0), busy[d], 1'b0);
      chk1(tag("midreset DONE", d, 0), done[d], 1'b0);
      chk_outputs("midreset", d, 0, 32'h0, 1'b0, 1'b0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) last_s[d] = '0;
    last_co = '0;
    last_ov = '0;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk1(tag("post-reset DONE", d, c), done[d], 1'b0);
        chk1(tag("post-reset BUSY", d, c), busy[d], 1'b0);
        chk32(tag("post-reset S", d, c), s_o[d], 32'h0);
      end
    end

    op($urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0);
    op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
